// File: rtl/ahb_lite_master.sv
// AHB-Lite manager: turns a valid/ready request stream into pipelined single
// transfers and returns read data and error status on a valid/ready response stream.
module ahb_lite_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter bit SEC_TRANS  = 1'b0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic                  HNONSEC,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "ahb_lite_master: DATA_WIDTH must be a power of 2 in 8..1024");
    end

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    // Address slot A: request currently presented on the bus
    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;

    // Data slot D: transfer currently in its data phase
    logic                  d_valid;
    logic                  d_write;
    logic [DATA_WIDTH-1:0] d_wdata;

    rsp_t       fifo [3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [1:0] f_count;

    logic                  accept;
    logic                  a_done;
    logic                  d_done;
    logic                  pop;
    logic [2:0]            size_c;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic [2:0]            outstanding;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        size_c       = (req_size > MAX_SIZE) ? MAX_SIZE : req_size;
        addr_aligned = req_addr & ({ADDR_WIDTH{1'b1}} << size_c);
        outstanding  = {2'b00, a_valid} + {2'b00, d_valid} + {1'b0, f_count};
        pop          = (f_count != 2'd0) && rsp_ready;
        // Counting this cycle's pop lets a zero-wait bus sustain one transfer per cycle
        req_ready    = !HRESET && (!a_valid || HREADY) && ((outstanding - {2'b00, pop}) < 3'd3);
        accept       = req_valid && req_ready;
        a_done       = a_valid && HREADY;
        d_done       = d_valid && HREADY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_addr  <= '0;
            a_size  <= '0;
            a_wdata <= '0;
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= '0;
        end else begin
            if (accept) begin
                a_valid <= 1'b1;
                a_write <= req_write;
                a_addr  <= addr_aligned;
                a_size  <= size_c;
                a_wdata <= req_wdata;
            end else if (a_done) begin
                a_valid <= 1'b0;
            end

            if (a_done) begin
                d_valid <= 1'b1;
                d_write <= a_write;
                d_wdata <= a_write ? a_wdata : '0;
            end else if (d_done) begin
                d_valid <= 1'b0;
            end
        end
    end

    // NOTE: the response storage is reset so rsp_rdata/rsp_err read back as zero after reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < 3; i++) fifo[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            f_count <= '0;
        end else begin
            if (d_done) begin
                fifo[wr_ptr] <= '{rdata: (d_write ? '0 : HRDATA), err: HRESP};
                wr_ptr       <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            f_count <= f_count + {1'b0, d_done} - {1'b0, pop};
        end
    end

    assign HTRANS    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HBURST    = 3'b000;
    assign HNONSEC   = !SEC_TRANS;
    assign HWDATA    = d_wdata;
    assign rsp_valid = (f_count != 2'd0);
    assign rsp_rdata = rsp_valid ? fifo[rd_ptr].rdata : '0;
    assign rsp_err   = rsp_valid ? fifo[rd_ptr].err : 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the AHB subordinate cycle by
// cycle and checks bus and response outputs against hand-computed values.
module tb_ahb_lite_master;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic          HNONSEC;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    int total = 0;
    int bad   = 0;
    int n_acc;
    int n_pop;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEC_TRANS(1'b0)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HNONSEC   (HNONSEC),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        HRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;

        // Reset state
        tick(); tick(); settle();
        check("rst_htrans",    64'(HTRANS),    64'd0);
        check("rst_haddr",     64'(HADDR),     64'd0);
        check("rst_hwdata",    64'(HWDATA),    64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("hburst",        64'(HBURST),    64'd0);
        check("hnonsec",       64'(HNONSEC),   64'd1);
        HRESET = 1'b0;
        settle();
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Single read, zero wait
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h104; req_size = 3'd2;
        tick();
        req_valid = 1'b0; HRDATA = 32'hDEADBEEF;
        settle();
        check("rd_htrans",  64'(HTRANS), 64'd2);
        check("rd_haddr",   64'(HADDR),  64'h104);
        check("rd_hwrite",  64'(HWRITE), 64'd0);
        check("rd_hsize",   64'(HSIZE),  64'd2);
        tick(); settle();
        check("rd_idle",      64'(HTRANS),    64'd0);
        check("rd_rsp_early", 64'(rsp_valid), 64'd0);
        tick(); settle();
        check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        check("rd_rsp_err",   64'(rsp_err),   64'd0);
        tick(); settle();
        check("rd_rsp_popped", 64'(rsp_valid), 64'd0);

        // Write with 2 wait states
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h010; req_size = 3'd2;
        req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        settle();
        check("wr_htrans", 64'(HTRANS), 64'd2);
        check("wr_hwrite", 64'(HWRITE), 64'd1);
        check("wr_haddr",  64'(HADDR),  64'h010);
        tick();
        HREADY = 1'b0;
        settle();
        check("wr_hwdata_c1", 64'(HWDATA), 64'h12345678);
        tick(); settle();
        check("wr_hwdata_c2", 64'(HWDATA),    64'h12345678);
        check("wr_no_rsp",    64'(rsp_valid), 64'd0);
        tick();
        HREADY = 1'b1;
        settle();
        check("wr_hwdata_c3", 64'(HWDATA), 64'h12345678);
        tick(); settle();
        check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("wr_rsp_err",   64'(rsp_err),   64'd0);
        tick(); settle();
        check("wr_rsp_popped", 64'(rsp_valid), 64'd0);

        // Back-to-back reads with rsp_ready held high
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'd2; req_addr = 12'h000;
        settle();
        check("b2b_ready0", 64'(req_ready), 64'd1);
        tick();
        req_addr = 12'h004;
        settle();
        check("b2b_haddr0", 64'(HADDR),     64'h000);
        check("b2b_ready1", 64'(req_ready), 64'd1);
        tick();
        req_addr = 12'h008; HRDATA = 32'h000000A0;
        settle();
        check("b2b_haddr1", 64'(HADDR),     64'h004);
        check("b2b_ready2", 64'(req_ready), 64'd1);
        tick();
        req_addr = 12'h00C; HRDATA = 32'h000000A4;
        settle();
        check("b2b_haddr2", 64'(HADDR),     64'h008);
        check("b2b_rsp0",   64'(rsp_rdata), 64'hA0);
        check("b2b_ready3", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0; HRDATA = 32'h000000A8;
        settle();
        check("b2b_haddr3",  64'(HADDR),     64'h00C);
        check("b2b_htrans3", 64'(HTRANS),    64'd2);
        check("b2b_rsp1",    64'(rsp_rdata), 64'hA4);
        tick();
        HRDATA = 32'h000000AC;
        settle();
        check("b2b_idle", 64'(HTRANS),    64'd0);
        check("b2b_rsp2", 64'(rsp_rdata), 64'hA8);
        tick(); settle();
        check("b2b_rsp3_valid", 64'(rsp_valid), 64'd1);
        check("b2b_rsp3",       64'(rsp_rdata), 64'hAC);
        tick(); settle();
        check("b2b_drained", 64'(rsp_valid), 64'd0);

        // Back-pressure: only 3 credits while responses are not consumed
        rsp_ready = 1'b0; HRDATA = 32'h00000055;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h020; req_size = 3'd2;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            settle();
            if (req_ready) n_acc++;
            tick();
        end
        settle();
        check("bp_accepted", 64'(n_acc),     64'd3);
        check("bp_blocked",  64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        settle();
        check("bp_reopen", 64'(req_ready), 64'd1);
        n_pop = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) n_pop++;
            tick();
            if (i == 0) req_valid = 1'b0;
            settle();
        end
        check("bp_pops",    64'(n_pop),     64'd4);
        check("bp_drained", 64'(rsp_valid), 64'd0);

        // Error on write, followed by a read held in the address slot
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'hFF0; req_size = 3'd2;
        req_wdata = 32'h00000BAD;
        tick();
        req_write = 1'b0; req_addr = 12'h000;
        settle();
        check("err_haddr",  64'(HADDR),     64'hFF0);
        check("err_hwrite", 64'(HWRITE),    64'd1);
        check("err_ready",  64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0; HRESP = 1'b1; HREADY = 1'b0;
        settle();
        check("err_next_htrans", 64'(HTRANS), 64'd2);
        check("err_next_haddr",  64'(HADDR),  64'h000);
        tick();
        HREADY = 1'b1;
        settle();
        check("err_addr_held",   64'(HADDR),     64'h000);
        check("err_trans_held",  64'(HTRANS),    64'd2);
        check("err_no_rsp_yet",  64'(rsp_valid), 64'd0);
        tick();
        HRESP = 1'b0; HRDATA = 32'h00000077;
        settle();
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_err",   64'(rsp_err),   64'd1);
        check("err_rsp_rdata", 64'(rsp_rdata), 64'd0);
        tick(); settle();
        check("after_err_valid", 64'(rsp_valid), 64'd1);
        check("after_err_err",   64'(rsp_err),   64'd0);
        check("after_err_rdata", 64'(rsp_rdata), 64'h77);
        tick(); settle();
        check("after_err_drained", 64'(rsp_valid), 64'd0);

        // Reset in the middle of a data phase
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h040; req_size = 3'd2;
        tick();
        req_valid = 1'b0;
        tick();
        HREADY = 1'b0; HRESET = 1'b1;
        tick(); settle();
        check("mid_rst_htrans",    64'(HTRANS),    64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        HRESET = 1'b0; HREADY = 1'b1; HRDATA = 32'h00000099;
        tick(); settle();
        check("mid_rst_abandoned", 64'(rsp_valid), 64'd0);

        // Size clamp and forced alignment after reset
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h00B; req_size = 3'd7;
        tick();
        req_addr = 12'h103; req_size = 3'd1;
        settle();
        check("clamp_hsize", 64'(HSIZE), 64'd2);
        check("clamp_haddr", 64'(HADDR), 64'h008);
        tick();
        req_valid = 1'b0; HRDATA = 32'hCAFEF00D;
        settle();
        check("align_hsize", 64'(HSIZE), 64'd1);
        check("align_haddr", 64'(HADDR), 64'h102);
        tick();
        HRDATA = 32'h00001234;
        settle();
        check("post_rst_rsp0", 64'(rsp_rdata), 64'hCAFEF00D);
        check("post_rst_err0", 64'(rsp_err),   64'd0);
        tick(); settle();
        check("post_rst_rsp1", 64'(rsp_rdata), 64'h1234);
        tick(); settle();
        check("post_rst_drained", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
